morse_timer: RTL and testbench
==============================

MORSE_TIMER -- requirements
Module: morse_timer

Interface
REQ-001 Parameter DEB_TICKS, default 2: consecutive ticks the synchronized key must disagree with the debounced key before the debounced key changes.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 tick  input  1  one-clk-wide time-base strobe; one tick is one duration count.
REQ-005 key  input  1  raw button, asynchronous, 1 = pressed.
REQ-006 ref_in  input  9  dot/dash threshold supplied by the downstream speed tracker.
REQ-007 lst_count  output  9  last measured mark or space duration, in ticks.
REQ-008 load  output  1  one-cycle strobe; lst_count and dashdit are valid while high.
REQ-009 dashdit  output  1  1 = long (dash or character gap); 0 = short (dot or intra-character gap).
REQ-010 sym_valid  output  1  one-cycle strobe qualifying sym.
REQ-011 sym  output  2  00 dot, 01 dash, 10 char end, 11 word end.

Function
REQ-012 key SHALL pass through a 2-flop synchronizer (key_s) before any other use.
REQ-013 The debounced key (key_db) SHALL take the value of key_s after DEB_TICKS consecutive ticks with key_s != key_db; any tick with key_s == key_db SHALL clear the debounce counter.
REQ-014 The duration counter SHALL be 9 bits and SHALL increment on tick only in state MARK or SPACE.
REQ-015 The duration counter SHALL saturate at 511 and not wrap.
REQ-016 The FSM states SHALL be IDLE, MARK and SPACE.
REQ-017 IDLE, key_db rising: SHALL go to MARK and clear the counter; no load and no sym_valid.
REQ-018 MARK, key_db falling: SHALL go to SPACE and clear the counter.
- On the same transition: load=1, lst_count=count, dashdit=(count > ref_in).
- Also: sym_valid=1, sym=01 if dashdit else 00.
REQ-019 SPACE, key_db rising: SHALL go to MARK and clear the counter.
- On the same transition: load=1, lst_count=count, dashdit=(count > ref_in).
- If dashdit=1: sym_valid=1, sym=10; otherwise no sym_valid.
REQ-020 SPACE, count > 2*ref_in (10-bit compare, evaluated every cycle): SHALL go to IDLE and emit sym_valid=1, sym=11; no load.
REQ-021 Word end SHALL imply char end; no separate 10 symbol SHALL be emitted for that gap.
REQ-022 Comparisons SHALL be strict greater-than; count == ref_in SHALL classify as short.
REQ-023 Latency: load and sym_valid SHALL assert in the clk cycle immediately after the cycle in which key_db changes, for exactly one cycle.
REQ-024 When a tick coincides with a key_db edge, the edge SHALL take priority: the captured count excludes that tick and the counter restarts at 0.
REQ-025 When REQ-019 and REQ-020 hold in the same cycle, REQ-020 SHALL take priority.
- The key_db rising edge is then processed from IDLE on the next cycle per REQ-017.
REQ-026 lst_count and dashdit SHALL hold their last values between load strobes.
REQ-027 A saturated MARK (count=511) SHALL report lst_count=511 on release.
REQ-028 ref_in SHALL be sampled in the cycle the decision is made; changes mid-interval are honoured.

Reset
REQ-029 rst_n low SHALL force, asynchronously:
- state=IDLE, counter=0, debounce counter=0, synchronizer and key_db=0;
- lst_count=0, load=0, dashdit=0, sym_valid=0, sym=00.
REQ-030 Reset asserted mid-MARK or mid-SPACE SHALL discard the interval with no load or sym_valid.
REQ-031 After release, the first press SHALL be handled per REQ-017.

Verification
REQ-032 Bench settings for all scenarios: ref_in=64, DEB_TICKS=2, tick every 4 clk.
- Press 40 ticks, release -> load, lst_count=40, dashdit=0, sym=00.
- Then 30-tick gap, press -> load, lst_count=30, dashdit=0, no sym_valid.
REQ-033 Press 200 ticks, release -> lst_count=200, dashdit=1, sym=01.
- Then 100-tick gap, press -> lst_count=100, dashdit=1, sym=10.
REQ-034 Release, hold released -> sym=11 exactly once when count reaches 129, state IDLE, no load.
- Next press -> no load or sym_valid on that press.
REQ-035 Hold pressed 600 ticks -> on release lst_count=511, dashdit=1, sym=01.
- Glitch: key high for 1 tick only -> no state change, no strobes.
REQ-036 Boundary: mark of exactly 64 ticks -> dashdit=0; mark of 65 ticks -> dashdit=1.
- Assert rst_n low at tick 20 of a mark -> all outputs 0 immediately, no load after release.

Source files
------------

// File: rtl/morse_timer_if.sv
// Bundle of the morse_timer time-base, key and measurement signals.
// The bench or upstream logic takes the master side; morse_timer takes the slave side.
interface morse_timer_if;
   logic       tick;
   logic       key;
   logic [8:0] ref_in;
   logic [8:0] lst_count;
   logic       load;
   logic       dashdit;
   logic       sym_valid;
   logic [1:0] sym;

   modport master (
      output tick, key, ref_in,
      input  lst_count, load, dashdit, sym_valid, sym
   );

   modport slave (
      input  tick, key, ref_in,
      output lst_count, load, dashdit, sym_valid, sym
   );
endinterface

// File: rtl/morse_timer.sv
// Morse key timer: synchronizes and debounces the key, measures mark/space
// durations in ticks and classifies them into dot/dash/char-end/word-end symbols.
module morse_timer #(
   parameter int unsigned DEB_TICKS = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   morse_timer_if.slave  bus
);

   localparam int unsigned DW = (DEB_TICKS < 2) ? 1 : $clog2(DEB_TICKS);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MARK,
      ST_SPACE
   } state_t;

   logic [1:0]    sync_q, sync_d;
   logic          key_s;
   logic [DW-1:0] deb_cnt_q, deb_cnt_d;
   logic          key_db_q, key_db_d;

   state_t        state_q, state_d;
   logic [8:0]    count_q, count_d;
   logic [8:0]    lst_count_q, lst_count_d;
   logic          load_q, load_d;
   logic          dashdit_q, dashdit_d;
   logic          sym_valid_q, sym_valid_d;
   logic [1:0]    sym_q, sym_d;

   logic          is_long;
   logic          word_end;
   logic [8:0]    count_inc;

   assign key_s = sync_q[1];

   always_comb begin
      sync_d = {sync_q[0], bus.key};
   end

   // key_db flips on the DEB_TICKS-th consecutive disagreeing tick
   always_comb begin
      deb_cnt_d = deb_cnt_q;
      key_db_d  = key_db_q;
      if (bus.tick) begin
         if (key_s != key_db_q) begin
            if (deb_cnt_q == DW'(DEB_TICKS - 1)) begin
               key_db_d  = key_s;
               deb_cnt_d = '0;
            end else begin
               deb_cnt_d = deb_cnt_q + DW'(1);
            end
         end else begin
            deb_cnt_d = '0;
         end
      end
   end

   assign is_long   = count_q > bus.ref_in;
   assign word_end  = {1'b0, count_q} > {bus.ref_in, 1'b0};
   assign count_inc = (bus.tick && count_q != '1) ? count_q + 9'd1 : count_q;

   // Edge handling wins over a coincident tick, so the captured count never includes it
   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      lst_count_d = lst_count_q;
      dashdit_d   = dashdit_q;
      load_d      = 1'b0;
      sym_valid_d = 1'b0;
      sym_d       = sym_q;
      unique case (state_q)
         ST_IDLE: begin
            if (key_db_q) begin
               state_d = ST_MARK;
               count_d = '0;
            end
         end
         ST_MARK: begin
            if (!key_db_q) begin
               state_d     = ST_SPACE;
               count_d     = '0;
               load_d      = 1'b1;
               lst_count_d = count_q;
               dashdit_d   = is_long;
               sym_valid_d = 1'b1;
               sym_d       = {1'b0, is_long};
            end else begin
               count_d = count_inc;
            end
         end
         ST_SPACE: begin
            // word end outranks a simultaneous press; that press is taken from IDLE next cycle
            if (word_end) begin
               state_d     = ST_IDLE;
               count_d     = '0;
               sym_valid_d = 1'b1;
               sym_d       = 2'b11;
            end else if (key_db_q) begin
               state_d     = ST_MARK;
               count_d     = '0;
               load_d      = 1'b1;
               lst_count_d = count_q;
               dashdit_d   = is_long;
               if (is_long) begin
                  sym_valid_d = 1'b1;
                  sym_d       = 2'b10;
               end
            end else begin
               count_d = count_inc;
            end
         end
         default: begin
            state_d = ST_IDLE;
            count_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q      <= '0;
         deb_cnt_q   <= '0;
         key_db_q    <= 1'b0;
         state_q     <= ST_IDLE;
         count_q     <= '0;
         lst_count_q <= '0;
         load_q      <= 1'b0;
         dashdit_q   <= 1'b0;
         sym_valid_q <= 1'b0;
         sym_q       <= '0;
      end else begin
         sync_q      <= sync_d;
         deb_cnt_q   <= deb_cnt_d;
         key_db_q    <= key_db_d;
         state_q     <= state_d;
         count_q     <= count_d;
         lst_count_q <= lst_count_d;
         load_q      <= load_d;
         dashdit_q   <= dashdit_d;
         sym_valid_q <= sym_valid_d;
         sym_q       <= sym_d;
      end
   end

   assign bus.lst_count = lst_count_q;
   assign bus.load      = load_q;
   assign bus.dashdit   = dashdit_q;
   assign bus.sym_valid = sym_valid_q;
   assign bus.sym       = sym_q;

endmodule

// File: tb/tb_morse_timer.sv
// Self-checking bench for morse_timer: per-cycle comparison against a tick-level
// behavioural model, plus literal checks on the logged load/symbol events.
module tb_morse_timer;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   morse_timer_if bus ();

   morse_timer #(.DEB_TICKS(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit ld;
      int lst;
      bit dd;
      bit sv;
      int sy;
   } ev_t;
   ev_t evq[$];

   // tick: one cycle high out of every four
   int unsigned phase = 0;
   initial begin
      bus.tick = 1'b0;
      forever begin
         @(negedge clk);
         bus.tick = (phase == 0);
         phase = (phase + 1) % 4;
      end
   end

   // model state: synchronizer stages, debounced key, disagreement run, mode, interval length
   int m_s1, m_ks, m_db, m_run, m_mode, m_len;
   int e_lst, e_sym;
   bit e_load, e_dash, e_sv;
   int sat, r;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_s1 = 0; m_ks = 0; m_db = 0; m_run = 0; m_mode = 0; m_len = 0;
         e_lst = 0; e_sym = 0; e_load = 0; e_dash = 0; e_sv = 0;
      end else begin
         r   = int'(bus.ref_in);
         sat = (m_len > 511) ? 511 : m_len;
         e_load = 0;
         e_sv   = 0;
         case (m_mode)
            0: if (m_db == 1) begin m_mode = 1; m_len = 0; end
            1: begin
               if (m_db == 0) begin
                  e_load = 1; e_lst = sat; e_dash = (sat > r);
                  e_sv = 1; e_sym = e_dash ? 1 : 0;
                  m_mode = 2; m_len = 0;
               end else if (bus.tick) m_len++;
            end
            default: begin
               if (sat > 2 * r) begin
                  e_sv = 1; e_sym = 3; m_mode = 0; m_len = 0;
               end else if (m_db == 1) begin
                  e_load = 1; e_lst = sat; e_dash = (sat > r);
                  if (e_dash) begin e_sv = 1; e_sym = 2; end
                  m_mode = 1; m_len = 0;
               end else if (bus.tick) m_len++;
            end
         endcase
         if (bus.tick) begin
            if (m_ks != m_db) begin
               m_run++;
               if (m_run >= 2) begin m_db = m_ks; m_run = 0; end
            end else m_run = 0;
         end
         m_ks = m_s1;
         m_s1 = int'(bus.key);
      end
      #1;
      checks++;
      if (bus.load !== e_load || bus.sym_valid !== e_sv || int'(bus.lst_count) != e_lst ||
          bus.dashdit !== e_dash || (e_sv && int'(bus.sym) != e_sym)) begin
         errors++;
         $display("FAIL cycle t=%0t load %0b want %0b sym_valid %0b want %0b lst_count %0d want %0d dashdit %0b want %0b sym %0d want %0d",
                  $time, bus.load, e_load, bus.sym_valid, e_sv, bus.lst_count, e_lst,
                  bus.dashdit, e_dash, bus.sym, e_sym);
      end
      if (bus.load === 1'b1 || bus.sym_valid === 1'b1)
         evq.push_back('{bus.load, int'(bus.lst_count), bus.dashdit, bus.sym_valid, int'(bus.sym)});
   end

   task automatic wait_ticks(input int n);
      repeat (n) begin
         @(posedge clk);
         while (!bus.tick) @(posedge clk);
      end
      @(negedge clk);
   endtask

   task automatic check_zero(input string name);
      checks++;
      if (bus.load !== 1'b0 || bus.sym_valid !== 1'b0 || bus.lst_count !== 9'd0 ||
          bus.dashdit !== 1'b0 || bus.sym !== 2'b00) begin
         errors++;
         $display("FAIL %s load=%0b sym_valid=%0b lst_count=%0d dashdit=%0b sym=%0d want all 0",
                  name, bus.load, bus.sym_valid, bus.lst_count, bus.dashdit, bus.sym);
      end
   endtask

   task automatic check_n(input string name, input int n);
      checks++;
      if (evq.size() != n) begin
         errors++;
         $display("FAIL %s event count %0d want %0d", name, evq.size(), n);
      end
   endtask

   task automatic check_ev(input string name, input int idx, input bit ld, input int lst,
                           input bit dd, input bit sv, input int sy);
      checks++;
      if (idx >= evq.size()) begin
         errors++;
         $display("FAIL %s event %0d missing want ld=%0b lst=%0d dd=%0b sv=%0b sym=%0d",
                  name, idx, ld, lst, dd, sv, sy);
      end else if (evq[idx].ld != ld || evq[idx].lst != lst || evq[idx].dd != dd ||
                   evq[idx].sv != sv || (sv && evq[idx].sy != sy)) begin
         errors++;
         $display("FAIL %s event %0d got ld=%0b lst=%0d dd=%0b sv=%0b sym=%0d want ld=%0b lst=%0d dd=%0b sv=%0b sym=%0d",
                  name, idx, evq[idx].ld, evq[idx].lst, evq[idx].dd, evq[idx].sv, evq[idx].sy,
                  ld, lst, dd, sv, sy);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "timeout");
   end

   initial begin
      bus.key    = 1'b0;
      bus.ref_in = 9'd64;
      repeat (5) @(negedge clk);
      check_zero("reset_state");
      rst_n = 1'b1;
      wait_ticks(4);

      // short mark then short gap
      evq.delete();
      bus.key = 1'b1; wait_ticks(40);
      bus.key = 1'b0; wait_ticks(30);
      bus.key = 1'b1; wait_ticks(5);
      check_n("dot_gap_n", 2);
      check_ev("dot", 0, 1, 40, 0, 1, 0);
      check_ev("short_gap", 1, 1, 30, 0, 0, 0);

      // long mark then char gap
      evq.delete();
      wait_ticks(195);
      bus.key = 1'b0; wait_ticks(100);
      bus.key = 1'b1; wait_ticks(5);
      check_n("dash_gap_n", 2);
      check_ev("dash", 0, 1, 200, 1, 1, 1);
      check_ev("char_gap", 1, 1, 100, 1, 1, 2);

      // word end, then a press from IDLE is silent
      evq.delete();
      wait_ticks(45);
      bus.key = 1'b0; wait_ticks(140);
      bus.key = 1'b1; wait_ticks(5);
      check_n("word_end_n", 2);
      check_ev("dot50", 0, 1, 50, 0, 1, 0);
      check_ev("word_end", 1, 0, 50, 0, 1, 3);

      // saturated mark, then one-tick glitch inside the space
      evq.delete();
      wait_ticks(595);
      bus.key = 1'b0; wait_ticks(10);
      bus.key = 1'b1; wait_ticks(1);
      bus.key = 1'b0; wait_ticks(140);
      check_n("sat_n", 2);
      check_ev("sat_dash", 0, 1, 511, 1, 1, 1);
      check_ev("sat_word_end", 1, 0, 511, 1, 1, 3);

      // threshold boundary: equal is short, one more is long
      evq.delete();
      bus.key = 1'b1; wait_ticks(64);
      bus.key = 1'b0; wait_ticks(140);
      bus.key = 1'b1; wait_ticks(65);
      bus.key = 1'b0; wait_ticks(140);
      check_n("bound_n", 4);
      check_ev("mark64", 0, 1, 64, 0, 1, 0);
      check_ev("mark64_we", 1, 0, 64, 0, 1, 3);
      check_ev("mark65", 2, 1, 65, 1, 1, 1);
      check_ev("mark65_we", 3, 0, 65, 1, 1, 3);

      // ref_in lowered mid-mark is honoured at the decision
      evq.delete();
      bus.key = 1'b1; wait_ticks(15);
      bus.ref_in = 9'd20; wait_ticks(15);
      bus.key = 1'b0; wait_ticks(50);
      check_n("ref_chg_n", 2);
      check_ev("ref_chg_dash", 0, 1, 30, 1, 1, 1);
      check_ev("ref_chg_we", 1, 0, 30, 1, 1, 3);
      bus.ref_in = 9'd64;

      // reset mid-mark discards the interval
      evq.delete();
      bus.key = 1'b1; wait_ticks(20);
      rst_n = 1'b0;
      #1;
      check_zero("async_reset");
      bus.key = 1'b0;
      repeat (10) @(negedge clk);
      rst_n = 1'b1;
      wait_ticks(20);
      check_n("reset_discard_n", 0);

      // first press after reset behaves as from IDLE
      bus.key = 1'b1; wait_ticks(10);
      bus.key = 1'b0; wait_ticks(5);
      check_n("post_reset_n", 1);
      check_ev("post_reset_dot", 0, 1, 10, 0, 1, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
